// File: rtl/pipe_io_port.sv
// Memory-mapped I/O port: debounced switch register, 7-segment hex display and change flag.
// Optional build macro IO_LZB_EN enables leading-zero blanking on the display.
module pipe_io_port #(
    parameter int unsigned       ADDR_W       = 32,
    parameter int unsigned       SW_W         = 10,
    parameter int unsigned       NUM_DIGITS   = 6,
    parameter int unsigned       DEBOUNCE_CYC = 16,
    parameter logic [ADDR_W-1:0] BASE_ADDR    = ADDR_W'(32'h80)
) (
    input  logic                    clock,
    input  logic                    resetn,
    input  logic [ADDR_W-1:0]       addr,
    input  logic [31:0]             wdata,
    input  logic                    we,
    input  logic                    re,
    output logic [31:0]             rdata,
    output logic                    rvalid,
    input  logic [SW_W-1:0]         sw,
    output logic [7*NUM_DIGITS-1:0] hex,
    output logic                    sw_changed
);

    localparam int unsigned HEX_W = 4 * NUM_DIGITS;
    localparam int unsigned CNT_W = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(DEBOUNCE_CYC - 1);
    localparam logic [ADDR_W-1:0] ADDR_SW   = BASE_ADDR;
    localparam logic [ADDR_W-1:0] ADDR_HEX  = BASE_ADDR + ADDR_W'(4);
    localparam logic [ADDR_W-1:0] ADDR_CTRL = BASE_ADDR + ADDR_W'(8);
    localparam logic [6:0]        SEG_BLANK = 7'b1111111;
    localparam logic [6:0]        SEG_ZERO  = 7'b1000000;

    // Active-low segment pattern {g..a} for one hex nibble
    function automatic logic [6:0] seg7(input logic [3:0] nib);
        logic [6:0] seg;
        case (nib)
            4'h0:    seg = 7'b1000000;
            4'h1:    seg = 7'b1111001;
            4'h2:    seg = 7'b0100100;
            4'h3:    seg = 7'b0110000;
            4'h4:    seg = 7'b0011001;
            4'h5:    seg = 7'b0010010;
            4'h6:    seg = 7'b0000010;
            4'h7:    seg = 7'b1111000;
            4'h8:    seg = 7'b0000000;
            4'h9:    seg = 7'b0010000;
            4'hA:    seg = 7'b0001000;
            4'hB:    seg = 7'b0000011;
            4'hC:    seg = 7'b1000110;
            4'hD:    seg = 7'b0100001;
            4'hE:    seg = 7'b0000110;
            4'hF:    seg = 7'b0001110;
            default: seg = SEG_BLANK;
        endcase
        return seg;
    endfunction

    logic [SW_W-1:0]         sync1_r;
    logic [SW_W-1:0]         sync2_r;
    logic [SW_W-1:0]         stable_r;
    logic [CNT_W-1:0]        cnt_r [SW_W];
    logic [SW_W-1:0]         accept_s;
    logic [HEX_W-1:0]        hexval_r;
    logic                    disp_en_r;
    logic                    flag_r;
    logic [31:0]             rdata_r;
    logic                    rvalid_r;
    logic [7*NUM_DIGITS-1:0] hex_r;
    logic [7*NUM_DIGITS-1:0] hex_s;
    logic [31:0]             rd_s;
    logic                    hit_sw_s;
    logic                    hit_hex_s;
    logic                    hit_ctrl_s;
    logic                    unused_wdata_s;

    assign hit_sw_s       = (addr == ADDR_SW);
    assign hit_hex_s      = (addr == ADDR_HEX);
    assign hit_ctrl_s     = (addr == ADDR_CTRL);
    assign unused_wdata_s = ^wdata;

    assign rdata      = rdata_r;
    assign rvalid     = rvalid_r;
    assign hex        = hex_r;
    assign sw_changed = flag_r;

    // A bit is accepted when it has disagreed with stable for DEBOUNCE_CYC cycles in a row
    always_comb begin
        accept_s = '0;
        for (int i = 0; i < SW_W; i++) begin
            if ((sync2_r[i] != stable_r[i]) && (cnt_r[i] == CNT_LAST)) begin
                accept_s[i] = 1'b1;
            end else begin
                accept_s[i] = 1'b0;
            end
        end
    end

    // Synchronizer, per-bit debounce counters and the accepted switch state
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            sync1_r  <= '0;
            sync2_r  <= '0;
            stable_r <= '0;
            for (int i = 0; i < SW_W; i++) begin
                cnt_r[i] <= '0;
            end
        end else begin
            sync1_r  <= sw;
            sync2_r  <= sync1_r;
            stable_r <= stable_r ^ accept_s;
            for (int i = 0; i < SW_W; i++) begin
                if ((sync2_r[i] == stable_r[i]) || accept_s[i]) begin
                    cnt_r[i] <= '0;
                end else begin
                    cnt_r[i] <= cnt_r[i] + CNT_W'(1);
                end
            end
        end
    end

    // Read mux over the pre-write register state
    always_comb begin
        rd_s = 32'd0;
        if (hit_sw_s) begin
            rd_s[SW_W-1:0] = stable_r;
        end else if (hit_hex_s) begin
            rd_s[HEX_W-1:0] = hexval_r;
        end else if (hit_ctrl_s) begin
            rd_s[1:0] = {flag_r, disp_en_r};
        end else begin
            rd_s = 32'd0;
        end
    end

`ifdef IO_LZB_EN
    logic [NUM_DIGITS-1:0] lead_s;
    logic                  above_s;

    // Mark digits that sit above the most significant nonzero digit
    always_comb begin
        lead_s  = '0;
        above_s = 1'b1;
        for (int i = NUM_DIGITS - 1; i > 0; i--) begin
            above_s   = above_s && (hexval_r[4*i +: 4] == 4'h0);
            lead_s[i] = above_s;
        end
    end
`endif

    // Segment decode with display enable and optional blanking
    always_comb begin
        hex_s = '1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (!disp_en_r) begin
                hex_s[7*i +: 7] = SEG_BLANK;
`ifdef IO_LZB_EN
            end else if (lead_s[i]) begin
                hex_s[7*i +: 7] = SEG_BLANK;
`endif
            end else begin
                hex_s[7*i +: 7] = seg7(hexval_r[4*i +: 4]);
            end
        end
    end

    // Bus registers, change flag and registered display/read outputs
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            hexval_r  <= '0;
            disp_en_r <= 1'b1;
            flag_r    <= 1'b0;
            rdata_r   <= 32'd0;
            rvalid_r  <= 1'b0;
            hex_r     <= {NUM_DIGITS{SEG_ZERO}};
        end else begin
            rvalid_r <= re;
            if (re) begin
                rdata_r <= rd_s;
            end
            if (we && hit_hex_s) begin
                hexval_r <= wdata[HEX_W-1:0];
            end
            if (we && hit_ctrl_s) begin
                disp_en_r <= wdata[0];
            end
            // A new switch change outranks a simultaneous W1C clear
            if (|accept_s) begin
                flag_r <= 1'b1;
            end else if (we && hit_ctrl_s && wdata[1]) begin
                flag_r <= 1'b0;
            end
            hex_r <= hex_s;
        end
    end

endmodule

// File: tb/tb_pipe_io_port.sv
// Self-checking bench for pipe_io_port: sliding-window debounce model plus register-map model,
// compared every cycle, with directed literal checks and a randomized phase.
module tb_pipe_io_port;

    localparam int          SW_W = 10;
    localparam int          ND   = 6;
    localparam int          DB   = 16;
    localparam logic [31:0] BASE = 32'h80;
    localparam logic [31:0] A_SW   = BASE;
    localparam logic [31:0] A_HEX  = BASE + 32'd4;
    localparam logic [31:0] A_CTRL = BASE + 32'd8;
`ifdef IO_LZB_EN
    localparam bit LZB = 1'b1;
`else
    localparam bit LZB = 1'b0;
`endif
    localparam logic [6:0] SEG [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

    logic             clock = 1'b0;
    logic             resetn = 1'b0;
    logic [31:0]      addr = 32'd0;
    logic [31:0]      wdata = 32'd0;
    logic             we = 1'b0;
    logic             re = 1'b0;
    logic [31:0]      rdata;
    logic             rvalid;
    logic [SW_W-1:0]  sw = '0;
    logic [7*ND-1:0]  hex;
    logic             sw_changed;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model state
    logic [31:0]     m_hexval;
    logic            m_disp_en;
    logic            m_flag;
    logic [SW_W-1:0] m_stable;
    logic [31:0]     m_rdata;
    logic            m_rvalid;
    logic [7*ND-1:0] m_hex;
    logic [SW_W-1:0] hist [0:DB];

    always #5 clock = ~clock;

    pipe_io_port #(
        .ADDR_W(32), .SW_W(SW_W), .NUM_DIGITS(ND), .DEBOUNCE_CYC(DB), .BASE_ADDR(BASE)
    ) dut (
        .clock(clock), .resetn(resetn), .addr(addr), .wdata(wdata), .we(we), .re(re),
        .rdata(rdata), .rvalid(rvalid), .sw(sw), .hex(hex), .sw_changed(sw_changed)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    function automatic logic [7*ND-1:0] disp(input logic [31:0] hv, input logic en);
        logic [7*ND-1:0] r;
        logic [3:0] nib;
        int nsig;
        nsig = 1;
        for (int k = 1; k < ND; k++) if (((hv >> (4*k)) & 32'hF) != 32'd0) nsig = k + 1;
        r = '0;
        for (int d = 0; d < ND; d++) begin
            nib = hv[4*d +: 4];
            if (!en) r[7*d +: 7] = 7'h7F;
            else if (LZB && d >= nsig) r[7*d +: 7] = 7'h7F;
            else r[7*d +: 7] = SEG[nib];
        end
        return r;
    endfunction

    task automatic model_reset();
        m_hexval  = 32'd0;
        m_disp_en = 1'b1;
        m_flag    = 1'b0;
        m_stable  = '0;
        m_rdata   = 32'd0;
        m_rvalid  = 1'b0;
        m_hex     = {ND{7'b1000000}};
        for (int k = 0; k <= DB; k++) hist[k] = '0;
    endtask

    // Effect of one rising edge; hist[k] is the switch value sampled k+1 edges ago
    task automatic model_edge();
        logic [31:0] rd;
        logic [SW_W-1:0] acc;
        logic [7*ND-1:0] nh;
        bit same;
        rd = 32'd0;
        if (addr == A_SW) rd = {22'd0, m_stable};
        else if (addr == A_HEX) rd = m_hexval;
        else if (addr == A_CTRL) rd = {30'd0, m_flag, m_disp_en};
        acc = '0;
        for (int b = 0; b < SW_W; b++) begin
            same = 1'b1;
            for (int k = 1; k <= DB; k++) if (hist[k][b] != hist[1][b]) same = 1'b0;
            if (same && hist[1][b] != m_stable[b]) acc[b] = 1'b1;
        end
        nh = disp(m_hexval, m_disp_en);
        if (we && addr == A_HEX) m_hexval = wdata & 32'h00FF_FFFF;
        if (we && addr == A_CTRL) m_disp_en = wdata[0];
        if (acc != '0) m_flag = 1'b1;
        else if (we && addr == A_CTRL && wdata[1]) m_flag = 1'b0;
        m_stable = m_stable ^ acc;
        for (int k = DB; k > 0; k--) hist[k] = hist[k-1];
        hist[0] = sw;
        m_rvalid = re;
        if (re) m_rdata = rd;
        m_hex = nh;
    endtask

    task automatic compare();
        chk("rvalid", 64'(rvalid), 64'(m_rvalid));
        chk("rdata", 64'(rdata), 64'(m_rdata));
        chk("hex", 64'(hex), 64'(m_hex));
        chk("sw_changed", 64'(sw_changed), 64'(m_flag));
    endtask

    task automatic cycle();
        @(posedge clock);
        model_edge();
        @(negedge clock);
        compare();
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        addr = a; wdata = d; we = 1'b1;
        cycle();
        we = 1'b0; addr = 32'd0;
    endtask

    task automatic rd(input logic [31:0] a, output logic [31:0] d);
        addr = a; re = 1'b1;
        cycle();
        re = 1'b0; addr = 32'd0;
        d = rdata;
    endtask

    initial begin
        logic [31:0]     v;
        logic [7*ND-1:0] e123456;
        logic [7*ND-1:0] elz;
        int              k;
        e123456 = {7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001, 7'b0010010, 7'b0000010};

        model_reset();
        repeat (3) @(negedge clock);
        chk("reset_hex", 64'(hex), 64'({ND{7'b1000000}}));
        chk("reset_rvalid", 64'(rvalid), 64'd0);
        chk("reset_flag", 64'(sw_changed), 64'd0);
        resetn = 1'b1;
        cycle();
        rd(A_CTRL, v);
        chk("ctrl_reset", 64'(v), 64'h1);

        wr(A_HEX, 32'h00123456);
        cycle();
        chk("hex_123456", 64'(hex), 64'(e123456));
        rd(A_HEX, v);
        chk("rd_hex", 64'(v), 64'h00123456);

        sw = 10'h201;
        repeat (17) cycle();
        chk("flag_before_accept", 64'(sw_changed), 64'd0);
        cycle();
        chk("flag_at_accept", 64'(sw_changed), 64'd1);
        rd(A_SW, v);
        chk("rd_sw", 64'(v), 64'h201);
        wr(A_CTRL, 32'h3);
        chk("flag_clear", 64'(sw_changed), 64'd0);
        sw = 10'h200;
        repeat (15) cycle();
        sw = 10'h201;
        repeat (20) cycle();
        rd(A_SW, v);
        chk("glitch_rejected", 64'(v), 64'h201);
        chk("glitch_no_flag", 64'(sw_changed), 64'd0);

        sw = 10'h200;
        repeat (17) cycle();
        wr(A_CTRL, 32'h3);
        chk("set_beats_clear", 64'(sw_changed), 64'd1);
        rd(A_SW, v);
        chk("rd_sw_200", 64'(v), 64'h200);
        wr(A_CTRL, 32'h3);
        chk("clear_later", 64'(sw_changed), 64'd0);

        wr(A_CTRL, 32'h0);
        cycle();
        chk("blank", 64'(hex), 64'({ND{7'h7F}}));
        wr(A_CTRL, 32'h1);
        cycle();
        chk("unblank", 64'(hex), 64'(e123456));
        rd(BASE + 32'hC, v);
        chk("unmapped_rdata", 64'(v), 64'd0);
        chk("unmapped_rvalid", 64'(rvalid), 64'd1);

        wr(A_HEX, 32'h00000A05);
        cycle();
        if (LZB) elz = {{3{7'h7F}}, 7'b0001000, 7'b1000000, 7'b0010010};
        else elz = {{3{7'b1000000}}, 7'b0001000, 7'b1000000, 7'b0010010};
        chk("hex_a05", 64'(hex), 64'(elz));

        for (int n = 0; n < 3000; n++) begin
            we = ($urandom_range(0, 3) == 0);
            re = ($urandom_range(0, 2) == 0);
            k = $urandom_range(0, 4);
            case (k)
                0: addr = A_SW;
                1: addr = A_HEX;
                2: addr = A_CTRL;
                3: addr = BASE + 32'hC;
                default: addr = BASE + 32'($urandom_range(0, 15));
            endcase
            wdata = $urandom;
            if (addr == A_CTRL && $urandom_range(0, 3) != 0) wdata[0] = 1'b1;
            k = $urandom_range(0, 19);
            if (k == 0) sw = SW_W'($urandom);
            else if (k == 1) sw = sw ^ (SW_W'(1) << $urandom_range(0, SW_W - 1));
            cycle();
        end
        we = 1'b0; re = 1'b0;

        addr = A_HEX; re = 1'b1;
        cycle();
        re = 1'b0;
        resetn = 1'b0;
        #1;
        chk("midreset_rvalid", 64'(rvalid), 64'd0);
        chk("midreset_rdata", 64'(rdata), 64'd0);
        chk("midreset_hex", 64'(hex), 64'({ND{7'b1000000}}));
        chk("midreset_flag", 64'(sw_changed), 64'd0);
        model_reset();
        sw = 10'h155;
        @(negedge clock);
        resetn = 1'b1;
        repeat (40) cycle();
        rd(A_SW, v);
        chk("sw_after_reset", 64'(v), 64'h155);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
